// File: rtl/pack_stream_to_blk_dbg_pkg.sv
// Shared types for the pack_stream_to_blk debug-path deadlock reporter:
// FSM state encoding, persistence counter width and the report record layout.
package pack_stream_to_blk_dbg_pkg;

  localparam int PCNT_W     = 16;
  localparam int RPT_MASK_W = 32;
  localparam int RPT_TS_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_REPORT  = 2'd2,
    ST_LATCHED = 2'd3
  } dl_state_e;

  // Fields are sized for the widest supported instance; the top slices them down.
  typedef struct packed {
    logic                  is_release;
    logic [RPT_MASK_W-1:0] src_mask;
    logic [RPT_TS_W-1:0]   timestamp;
  } rpt_rec_t;

endpackage

// File: rtl/pack_stream_to_blk_dbg_persist_cnt.sv
// Saturating run-length counter: clr zeroes, start loads 1, inc counts up to limit.
// hit is high while the count sits at the limit.
module pack_stream_to_blk_dbg_persist_cnt
  import pack_stream_to_blk_dbg_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              start,
  input  logic              inc,
  input  logic [PCNT_W-1:0] limit,
  output logic [PCNT_W-1:0] count,
  output logic              hit
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (start) begin
      count <= PCNT_W'(1);
    end else if (inc && (count < limit)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/pack_stream_to_blk_hls_deadlock_report.sv
// Qualifies persistent monitor block conditions and emits one report record per episode.
// Optional release reporting is enabled by defining HLS_DEADLOCK_RELEASE_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no block seen, waiting for any block_sigs bit
// ST_ARMED   | block persisting, counting cycles and accumulating the mask
// ST_REPORT  | record presented on rpt_valid, waiting for rpt_ready
// ST_LATCHED | deadlock reported, block inputs ignored until clear/release
module pack_stream_to_blk_hls_deadlock_report
  import pack_stream_to_blk_dbg_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_W           = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] block_sigs,
  input  logic               clear,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [NUM_SRC-1:0] rpt_src_mask,
  output logic [TS_W-1:0]    rpt_timestamp,
  output logic               rpt_release,
  output logic               deadlock
);

  localparam logic [PCNT_W-1:0] LIMIT = PCNT_W'(PERSIST_CYCLES);

  dl_state_e          state_q, state_d;
  logic [TS_W-1:0]    ts_q;
  logic [NUM_SRC-1:0] acc_mask_q, acc_mask_d;
  rpt_rec_t           rec_q, rec_d;
  logic               deadlock_q, deadlock_d;

  logic               any_blk;
  logic               qualify;
  logic               rel_fire;
  logic               p_start, p_inc, p_clr, p_hit;
  logic [PCNT_W-1:0]  persist_cnt;

  assign any_blk = |block_sigs;
  assign p_start = (state_q == ST_IDLE) && any_blk;
  assign p_inc   = (state_q == ST_ARMED) && any_blk;
  assign qualify = p_inc && p_hit;
  assign p_clr   = clear || qualify || !(p_start || p_inc);

  pack_stream_to_blk_dbg_persist_cnt u_persist_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (p_clr),
    .start (p_start),
    .inc   (p_inc),
    .limit (LIMIT),
    .count (persist_cnt),
    .hit   (p_hit)
  );

`ifdef HLS_DEADLOCK_RELEASE_EN
  logic              r_inc, r_hit;
  logic [PCNT_W-1:0] rel_cnt;

  // Release needs an unbroken run of idle cycles; any block restarts it.
  assign r_inc    = (state_q == ST_LATCHED) && !any_blk;
  assign rel_fire = r_inc && r_hit;

  pack_stream_to_blk_dbg_persist_cnt u_rel_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clear || rel_fire || !r_inc),
    .start (1'b0),
    .inc   (r_inc),
    .limit (LIMIT),
    .count (rel_cnt),
    .hit   (r_hit)
  );

  logic unused_rel;
  assign unused_rel  = ^rel_cnt;
  assign rpt_release = rec_q.is_release;
`else
  assign rel_fire    = 1'b0;
  assign rpt_release = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    acc_mask_d = acc_mask_q;
    rec_d      = rec_q;
    deadlock_d = deadlock_q;
    case (state_q)
      ST_IDLE: begin
        if (any_blk) begin
          state_d    = ST_ARMED;
          acc_mask_d = block_sigs;
        end
      end
      ST_ARMED: begin
        if (!any_blk) begin
          state_d    = ST_IDLE;
          acc_mask_d = '0;
        end else if (p_hit) begin
          state_d         = ST_REPORT;
          rec_d.is_release = 1'b0;
          rec_d.src_mask  = RPT_MASK_W'(acc_mask_q | block_sigs);
          rec_d.timestamp = RPT_TS_W'(ts_q);
          deadlock_d      = 1'b1;
          acc_mask_d      = '0;
        end else begin
          acc_mask_d = acc_mask_q | block_sigs;
        end
      end
      ST_REPORT: begin
        if (rpt_ready) begin
          if (rec_q.is_release) begin
            state_d    = ST_IDLE;
            deadlock_d = 1'b0;
          end else begin
            state_d = ST_LATCHED;
          end
        end
      end
      ST_LATCHED: begin
        if (rel_fire) begin
          state_d          = ST_REPORT;
          rec_d.is_release = 1'b1;
          rec_d.src_mask   = '0;
          rec_d.timestamp  = RPT_TS_W'(ts_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // clear beats every transition, including a handshake or qualification this cycle
    if (clear) begin
      state_d    = ST_IDLE;
      acc_mask_d = '0;
      deadlock_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      acc_mask_q <= '0;
      rec_q      <= '0;
      deadlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + 1'b1;
      acc_mask_q <= acc_mask_d;
      rec_q      <= rec_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign rpt_valid     = (state_q == ST_REPORT);
  assign rpt_src_mask  = rec_q.src_mask[NUM_SRC-1:0];
  assign rpt_timestamp = rec_q.timestamp[TS_W-1:0];
  assign deadlock      = deadlock_q;

  logic unused_bits;
  assign unused_bits = ^{rec_q, persist_cnt};

endmodule

// File: tb/tb_pack_stream_to_blk_hls_deadlock_report.sv
// Directed bench for pack_stream_to_blk_hls_deadlock_report (default and TS_W=4 instances).
module tb_pack_stream_to_blk_hls_deadlock_report;

  logic        clock;
  logic        reset;

  logic [1:0]  blk_a, mask_a;
  logic        clr_a, rdy_a, vld_a, rel_a, dl_a;
  logic [31:0] ts_a;

  logic [1:0]  blk_b, mask_b;
  logic        clr_b, rdy_b, vld_b, rel_b, dl_b;
  logic [3:0]  ts_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  pack_stream_to_blk_hls_deadlock_report #(
    .NUM_SRC(2), .PERSIST_CYCLES(16), .TS_W(32)
  ) u_dut_a (
    .clock         (clock),
    .reset         (reset),
    .block_sigs    (blk_a),
    .clear         (clr_a),
    .rpt_valid     (vld_a),
    .rpt_ready     (rdy_a),
    .rpt_src_mask  (mask_a),
    .rpt_timestamp (ts_a),
    .rpt_release   (rel_a),
    .deadlock      (dl_a)
  );

  pack_stream_to_blk_hls_deadlock_report #(
    .NUM_SRC(2), .PERSIST_CYCLES(1), .TS_W(4)
  ) u_dut_b (
    .clock         (clock),
    .reset         (reset),
    .block_sigs    (blk_b),
    .clear         (clr_b),
    .rpt_valid     (vld_b),
    .rpt_ready     (rdy_b),
    .rpt_src_mask  (mask_b),
    .rpt_timestamp (ts_b),
    .rpt_release   (rel_b),
    .deadlock      (dl_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic pulse_clear();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  initial begin
    int  c0;
    int  hs;
    logic saw;
    logic stable;

    reset = 1'b0;
    blk_a = '0; clr_a = 1'b0; rdy_a = 1'b0;
    blk_b = '0; clr_b = 1'b0; rdy_b = 1'b0;
    repeat (2) @(negedge clock);

    check_eq("rst_vld",  vld_a,  0);
    check_eq("rst_mask", mask_a, 0);
    check_eq("rst_ts",   ts_a,   0);
    check_eq("rst_rel",  rel_a,  0);
    check_eq("rst_dl",   dl_a,   0);
    check_eq("rst_vld_b", vld_b, 0);

    reset = 1'b1;
    cyc   = 0;

    // TS_W=4, PERSIST_CYCLES=1: block starts with ts=0 after wrap, captured ts = 17 mod 16
    repeat (16) tick();
    blk_b = 2'b01;
    tick();
    check_eq("b_vld_early", vld_b, 0);
    tick();
    check_eq("b_vld",  vld_b,  1);
    check_eq("b_ts",   ts_b,   1);
    check_eq("b_mask", mask_b, 2'b01);
    check_eq("b_rel",  rel_b,  0);
    check_eq("b_dl",   dl_b,   1);
    rdy_b = 1'b1;
    tick();
    check_eq("b_vld_after_hs", vld_b, 0);
    blk_b = '0;
    rdy_b = 1'b0;

    // basic qualification: valid exactly 17 cycles after onset, one cycle long
    c0 = cyc;
    blk_a = 2'b01;
    rdy_a = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("t1_vld_k%0d", k), vld_a, (k == 17));
      if (k == 16) check_eq("t1_dl_pre", dl_a, 0);
      if (k == 17) begin
        check_eq("t1_mask", mask_a, 2'b01);
        check_eq("t1_ts",   ts_a,   32'(c0 + 16));
        check_eq("t1_rel",  rel_a,  0);
      end
    end
    check_eq("t1_dl_sticky", dl_a, 1);
    blk_a = '0;
    tick();
    pulse_clear();
    check_eq("t1_dl_cleared", dl_a, 0);

    // broken persistence never qualifies
    saw = 1'b0;
    blk_a = 2'b01;
    repeat (15) begin tick(); saw |= vld_a; end
    blk_a = 2'b00;
    tick(); saw |= vld_a;
    blk_a = 2'b10;
    repeat (15) begin tick(); saw |= vld_a; end
    blk_a = 2'b00;
    repeat (3) begin tick(); saw |= vld_a; end
    check_eq("t2_no_rpt", saw, 0);
    check_eq("t2_dl", dl_a, 0);

    // backpressure: record held stable, mask accumulates both sources
    c0 = cyc;
    rdy_a = 1'b0;
    blk_a = 2'b01;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 8) blk_a = 2'b10;
    end
    check_eq("t3_vld",  vld_a,  1);
    check_eq("t3_mask", mask_a, 2'b11);
    check_eq("t3_ts",   ts_a,   32'(c0 + 16));
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!(vld_a === 1'b1 && mask_a === 2'b11 && ts_a === 32'(c0 + 16))) stable = 1'b0;
    end
    check_eq("t3_stable", stable, 1);
    rdy_a = 1'b1;
    hs = 0;
    repeat (5) begin
      if (vld_a && rdy_a) hs++;
      tick();
    end
    check_eq("t3_one_hs", hs, 1);
    check_eq("t3_vld_low", vld_a, 0);
    check_eq("t3_dl", dl_a, 1);
    rdy_a = 1'b0;
    blk_a = '0;
    pulse_clear();

    // clear in the qualifying cycle wins
    blk_a = 2'b01;
    repeat (16) tick();
    clr_a = 1'b1;
    tick();
    check_eq("t4a_vld", vld_a, 0);
    check_eq("t4a_dl",  dl_a,  0);
    clr_a = 1'b0;
    blk_a = '0;
    tick();
    check_eq("t4a_vld_after", vld_a, 0);

    // clear while a record is pending abandons it
    blk_a = 2'b01;
    repeat (17) tick();
    check_eq("t4b_vld_pre", vld_a, 1);
    clr_a = 1'b1;
    tick();
    check_eq("t4b_vld", vld_a, 0);
    check_eq("t4b_dl",  dl_a,  0);
    clr_a = 1'b0;
    blk_a = '0;
    tick();

    // asynchronous reset mid-REPORT
    blk_a = 2'b01;
    repeat (17) tick();
    check_eq("t5_vld_pre", vld_a, 1);
    check_eq("t5_dl_pre",  dl_a,  1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_vld_async", vld_a, 0);
    check_eq("t5_dl_async",  dl_a,  0);
    check_eq("t5_mask_async", mask_a, 0);
    @(negedge clock);
    reset = 1'b1;
    blk_a = '0;
    cyc = 0;
    tick();

    // release reporting
    blk_a = 2'b01;
    rdy_a = 1'b1;
    repeat (17) tick();
    check_eq("t6_vld_first", vld_a, 1);
    check_eq("t6_rel_first", rel_a, 0);
    blk_a = '0;
`ifdef HLS_DEADLOCK_RELEASE_EN
    saw = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (vld_a) begin saw = 1'b1; break; end
    end
    check_eq("t6_rel_seen", saw, 1);
    check_eq("t6_rel",      rel_a,  1);
    check_eq("t6_rel_mask", mask_a, 0);
    check_eq("t6_dl_held",  dl_a,   1);
    tick();
    check_eq("t6_vld_done", vld_a, 0);
    check_eq("t6_dl_rel",   dl_a,  0);
`else
    saw = 1'b0;
    repeat (40) begin tick(); saw |= vld_a; end
    check_eq("t6_no_second", saw, 0);
    check_eq("t6_dl_stays", dl_a, 1);
    pulse_clear();
    check_eq("t6_dl_clr", dl_a, 0);
`endif
    rdy_a = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
